mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the execute stage, downstream of the controller and GRF read ports. Takes rs/rt operands and drives HI/LO for mfhi/mflo writeback.
- Exposes `busy` so upstream fetch/decode stalls any MDU-class instruction while an operation is in flight.

---
 rtl/mult_div_unit_pkg.sv | 31 +++
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 tb/tb_mult_div_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared MDU definitions: operation codes, default latencies, writeback-select codes.
// Optional accumulate ops (madd/maddu/msub/msubu) are only decoded when MDU_MADD_EN is defined.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    // Writeback-mux select extension for mfhi/mflo
    localparam logic [2:0] WDSEL_HI = 3'd4;
    localparam logic [2:0] WDSEL_LO = 3'd5;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO; MULT_CYCLES/DIV_CYCLES busy cycles, mthi/mtlo in one edge.
// No backpressure: a start while busy is silently dropped, upstream must stall on busy. Optional macro: MDU_MADD_EN.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    mdu_state_e  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] hi_q, hi_nxt, lo_q, lo_nxt;
    logic [31:0] sh_hi, sh_hi_nxt, sh_lo, sh_lo_nxt;
    logic        commit, commit_nxt;

    logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    logic [31:0] b_safe, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic        b_zero;

    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign a_zx   = {32'd0, A};
    assign b_zx   = {32'd0, B};
    // Low 64 bits of the sign-extended product equal the true signed product
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Divide by a safe nonzero value; a zero divisor never commits anyway
    assign b_zero = (B == 32'd0);
    assign b_safe = b_zero ? 32'd1 : B;
    assign q_u    = A / b_safe;
    assign r_u    = A % b_safe;
    assign a_mag  = A[31] ? (~A + 32'd1) : A;
    assign b_mag  = B[31] ? (~B + 32'd1) : b_safe;
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    assign q_s    = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s    = A[31] ? (~r_mag + 32'd1) : r_mag;

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_q, lo_q};
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;
        sh_hi_nxt  = sh_hi;
        sh_lo_nxt  = sh_lo;
        commit_nxt = commit;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (MDUOp)
                        OP_MTHI: hi_nxt = A;
                        OP_MTLO: lo_nxt = A;
                        OP_MULT, OP_MULTU: begin
                            {sh_hi_nxt, sh_lo_nxt} = (MDUOp == OP_MULT) ? prod_s : prod_u;
                            commit_nxt = 1'b1;
                            cnt_nxt    = MULT_LAT;
                            state_nxt  = ST_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            sh_lo_nxt  = (MDUOp == OP_DIV) ? q_s : q_u;
                            sh_hi_nxt  = (MDUOp == OP_DIV) ? r_s : r_u;
                            commit_nxt = !b_zero;
                            cnt_nxt    = DIV_LAT;
                            state_nxt  = ST_BUSY;
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            case (MDUOp)
                                OP_MADD:  {sh_hi_nxt, sh_lo_nxt} = acc + prod_s;
                                OP_MADDU: {sh_hi_nxt, sh_lo_nxt} = acc + prod_u;
                                OP_MSUB:  {sh_hi_nxt, sh_lo_nxt} = acc - prod_s;
                                default:  {sh_hi_nxt, sh_lo_nxt} = acc - prod_u;
                            endcase
                            commit_nxt = 1'b1;
                            cnt_nxt    = MULT_LAT;
                            state_nxt  = ST_BUSY;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: begin
                if (cnt == 4'd1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_IDLE;
                    if (commit) begin
                        hi_nxt = sh_hi;
                        lo_nxt = sh_lo;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            sh_hi  <= 32'd0;
            sh_lo  <= 32'd0;
            commit <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
            sh_hi  <= sh_hi_nxt;
            sh_lo  <= sh_lo_nxt;
            commit <= commit_nxt;
        end
    end

    assign busy = (state == ST_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results and busy durations.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, busy;
    logic [3:0]  MDUOp;
    logic [31:0] A, B, HI, LO;
    int          total = 0;
    int          bad = 0;
    int          n;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns just after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        step();
        start = 1'b0;
    endtask

    // Counts observed busy cycles, bounded so a stuck busy still terminates
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        MDUOp = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);

        // mult -3 * 5
        issue(4'd1, 32'hFFFFFFFD, 32'd5);
        chk("mult_busy_rise", {31'd0, busy}, 32'd1);
        chk("mult_hi_hold", HI, 32'd0);
        chk("mult_lo_hold", LO, 32'd0);
        step();
        chk("mult_hi_hold2", HI, 32'd0);
        wait_idle(n);
        chk("mult_busy_len", n, 32'd4);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFF1);

        // divu / div with same operands
        issue(4'd4, 32'hFFFFFFFF, 32'd16);
        wait_idle(n);
        chk("divu_busy_len", n, 32'd10);
        chk("divu_lo", LO, 32'h0FFFFFFF);
        chk("divu_hi", HI, 32'h0000000F);
        issue(4'd3, 32'hFFFFFFFF, 32'd16);
        wait_idle(n);
        chk("div_m1_lo", LO, 32'h00000000);
        chk("div_m1_hi", HI, 32'hFFFFFFFF);

        // div -7 / 2, then divide by zero leaves HI/LO alone
        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        chk("div_m7_lo", LO, 32'hFFFFFFFD);
        chk("div_m7_hi", HI, 32'hFFFFFFFF);
        issue(4'd3, 32'd123, 32'd0);
        wait_idle(n);
        chk("div0_busy_len", n, 32'd10);
        chk("div0_lo", LO, 32'hFFFFFFFD);
        chk("div0_hi", HI, 32'hFFFFFFFF);

        // signed overflow wraps
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        chk("div_ovf_lo", LO, 32'h80000000);
        chk("div_ovf_hi", HI, 32'h00000000);

        // mthi then mtlo on consecutive cycles
        issue(4'd5, 32'h12345678, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", HI, 32'h12345678);
        issue(4'd6, 32'h9ABCDEF0, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_lo", LO, 32'h9ABCDEF0);
        chk("mtlo_hi_kept", HI, 32'h12345678);

        // unknown / none ops are no-ops
        issue(4'd15, 32'hDEADBEEF, 32'd3);
        chk("unk_busy", {31'd0, busy}, 32'd0);
        chk("unk_hi", HI, 32'h12345678);
        issue(4'd0, 32'hDEADBEEF, 32'd3);
        chk("none_lo", LO, 32'h9ABCDEF0);

        // multu 2*3, second request held during busy is dropped
        issue(4'd2, 32'd2, 32'd3);
        start = 1'b1;
        MDUOp = 4'd2;
        A     = 32'd7;
        B     = 32'd7;
        wait_idle(n);
        chk("hold_busy_len", n, 32'd5);
        chk("hold_hi", HI, 32'd0);
        chk("hold_lo", LO, 32'd6);
        step();
        start = 1'b0;
        chk("hold_reaccept", {31'd0, busy}, 32'd1);
        wait_idle(n);
        chk("hold_lo49", LO, 32'd49);

        // reset on third busy cycle discards the in-flight result
        issue(4'd1, 32'h00010000, 32'h00010000);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        for (int i = 0; i < 6; i++) step();
        chk("rstmid_late_hi", HI, 32'd0);
        chk("rstmid_late_lo", LO, 32'd0);

        issue(4'd6, 32'd10, 32'd0);
        chk("acc_seed_lo", LO, 32'd10);
`ifdef MDU_MADD_EN
        issue(4'd7, 32'd3, 32'd4);
        wait_idle(n);
        chk("madd_busy_len", n, 32'd5);
        chk("madd_lo", LO, 32'd22);
        chk("madd_hi", HI, 32'd0);
        issue(4'd9, 32'd5, 32'd5);
        wait_idle(n);
        chk("msub_lo", LO, 32'hFFFFFFFD);
        chk("msub_hi", HI, 32'hFFFFFFFF);
`else
        issue(4'd7, 32'd3, 32'd4);
        chk("madd_off_busy", {31'd0, busy}, 32'd0);
        step();
        chk("madd_off_lo", LO, 32'd10);
        chk("madd_off_hi", HI, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
